rv_iopmp_err_capture: RTL
=========================

// Module: rv_iopmp_err_capture
// PURPOSE
// - Consumer end of the decision-logic error interface. Latches the first faulting transaction into
//   the ERR_REQINFO/ERR_REQADDR/ERR_REQID record and holds it until software clears it.
// - Raises the IOPMP wired interrupt and counts follow-on errors while the record is full.
// - Sits between rv_iopmp_dl_* (error source) and the IOPMP register file (software view).
// PARAMETERS
// - SID_WIDTH       8   width of source ID
// - ADDR_WIDTH      64  width of transaction address
// - EIDX_WIDTH      16  width of err_entry_index_i / recorded entry ID
// - OVF_CNT_WIDTH   8   width of saturating overflow counter
// PORTS
// - clk_i              in   1              clock
// - rst_i              in   1              async reset, active-high
// - err_valid_i        in   1              DL outputs valid this cycle (one transaction decided)
// - err_transaction_i  in   1              DL flagged an error (qualified by err_valid_i)
// - err_type_i         in   3              DL error type (1 rd, 2 wr, 3 exec, 5 no-hit, 6 unknown SID, 7 other)
// - err_entry_index_i  in   EIDX_WIDTH     faulting entry index from DL
// - sid_i              in   SID_WIDTH      SID of decided transaction
// - addr_i             in   ADDR_WIDTH     address of decided transaction
// - access_type_i      in   rv_iopmp_pkg::access_t  access type of decided transaction
// - ie_i               in   1              interrupt enable (ERR_CFG.ie)
// - err_clr_i          in   1              one-cycle pulse: software wrote 1 to ERR_REQINFO.v
// - err_v_o            out  1              record valid
// - err_ttype_o        out  2              recorded access type
// - err_etype_o        out  3              recorded error type
// - err_addr_o         out  ADDR_WIDTH     recorded address
// - err_sid_o          out  SID_WIDTH      recorded SID
// - err_eid_o          out  EIDX_WIDTH     recorded entry index
// - err_ovf_o          out  1              sticky: error dropped while record valid
// - ovf_cnt_o          out  OVF_CNT_WIDTH  dropped-error count, saturating
// - irq_o              out  1              wired interrupt
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE.
// - err_hit = err_valid_i & err_transaction_i. err_transaction_i without err_valid_i is ignored.
// - FSM has two states.
//   - IDLE: on err_hit, register all record fields; next cycle LOGGED with err_v_o=1 (latency 1).
//   - LOGGED: record frozen. err_hit sets err_ovf_o and increments ovf_cnt_o, saturating at all-ones (no wrap).
//     err_clr_i returns to IDLE and clears err_v_o, err_ovf_o and ovf_cnt_o the next cycle.
// - err_clr_i and err_hit in the same LOGGED cycle: clear, then capture the new error.
//   - Next cycle: state LOGGED, new record, ovf cleared.
// - err_clr_i in IDLE: no effect. Record fields retain their last values in IDLE; they are only
//   updated on capture.
// - irq_o = err_v_o & ie_i. Combinational from registered state; no latency from ie_i toggling.
// - Reset mid-operation: immediate return to IDLE with all outputs 0; any pending MSI is dropped.
// - All fields are captured verbatim; no width conversion. err_eid_o is as supplied (0 for types 5/6).
// CONFIGURATION
// - Macro RV_IOPMP_ERR_MSI_EN adds ports:
//   - msi_addr_i  in   ADDR_WIDTH
//   - msi_data_i  in   11
//   - msi_en_i    in   1
//   - msi_req_o   out  1
//   - msi_ready_i in   1
//   - msi_addr_o  out  ADDR_WIDTH
//   - msi_data_o  out  11
// - With the macro, the FSM gains state MSI_PEND, entered from a capture when ie_i & msi_en_i.
//   - msi_req_o=1, with addr/data sampled at capture, is held stable until msi_ready_i.
//   - Then the FSM goes to LOGGED (err_clr_i in MSI_PEND is deferred until the handshake completes).
//   - err_v_o=1 throughout MSI_PEND; drops are counted there as well.
//   - irq_o is forced 0 when msi_en_i=1.
// - Without the macro: no MSI ports, no MSI_PEND state, irq_o as above.
// TESTING
// - Reset, then err_valid=1 err_transaction=1 type=2 sid=1 addr=0x8000_0040 eid=5 ie=1
//   -> next cycle err_v=1, etype=2, eid=5, irq=1.
// - Second error (type=5) while LOGGED -> record unchanged, ovf=1, ovf_cnt=1;
//   300 more errors -> ovf_cnt=255 (saturates).
// - err_clr and a new error (type=1, addr=0x100) in the same cycle -> err_v=1, etype=1, addr=0x100, ovf=0, ovf_cnt=0.
// - err_transaction=1 with err_valid=0 -> no capture; ie=0 with an error -> err_v=1, irq=0;
//   raising ie -> irq=1 the same cycle.
// - MSI_EN build, msi_en=1: capture -> msi_req=1 with msi_ready=0 for 4 cycles (addr/data stable);
//   err_clr in that window is deferred -> msi_ready=1, then clear takes effect.
// - Assert rst_i while LOGGED with ovf_cnt=3 -> all outputs 0 immediately; no capture in the reset cycle.

Source files
------------

// File: rtl/rv_iopmp_pkg.sv
// +------------------------------------------------------------------+
// | rv_iopmp_pkg : shared IOPMP types                                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package rv_iopmp_pkg;
  // Transaction access type as carried on the decision-logic outputs.
  typedef logic [1:0] access_t;
endpackage

`default_nettype wire

// File: rtl/rv_iopmp_err_capture_if.sv
// +------------------------------------------------------------------+
// | rv_iopmp_err_capture_if : decision-logic error report bundle     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface rv_iopmp_err_capture_if #(
  parameter int SID_WIDTH  = 8,
  parameter int ADDR_WIDTH = 64,
  parameter int EIDX_WIDTH = 16
);
  logic                    err_valid;
  logic                    err_transaction;
  logic [2:0]              err_type;
  logic [EIDX_WIDTH-1:0]   err_entry_index;
  logic [SID_WIDTH-1:0]    sid;
  logic [ADDR_WIDTH-1:0]   addr;
  rv_iopmp_pkg::access_t   access_type;

  modport master (
    output err_valid, err_transaction, err_type, err_entry_index, sid, addr, access_type
  );

  modport slave (
    input  err_valid, err_transaction, err_type, err_entry_index, sid, addr, access_type
  );
endinterface

`default_nettype wire

// File: rtl/rv_iopmp_err_capture.sv
// +------------------------------------------------------------------+
// | rv_iopmp_err_capture : first-error record, overflow count, IRQ   |
// | Optional MSI signalling with macro RV_IOPMP_ERR_MSI_EN. Rev 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module rv_iopmp_err_capture #(
  parameter int SID_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 64,
  parameter int EIDX_WIDTH    = 16,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  rv_iopmp_err_capture_if.slave    dl,
  input  logic                     ie_i,
  input  logic                     err_clr_i,
`ifdef RV_IOPMP_ERR_MSI_EN
  input  logic [ADDR_WIDTH-1:0]    msi_addr_i,
  input  logic [10:0]              msi_data_i,
  input  logic                     msi_en_i,
  output logic                     msi_req_o,
  input  logic                     msi_ready_i,
  output logic [ADDR_WIDTH-1:0]    msi_addr_o,
  output logic [10:0]              msi_data_o,
`endif
  output logic                     err_v_o,
  output logic [1:0]               err_ttype_o,
  output logic [2:0]               err_etype_o,
  output logic [ADDR_WIDTH-1:0]    err_addr_o,
  output logic [SID_WIDTH-1:0]     err_sid_o,
  output logic [EIDX_WIDTH-1:0]    err_eid_o,
  output logic                     err_ovf_o,
  output logic [OVF_CNT_WIDTH-1:0] ovf_cnt_o,
  output logic                     irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOGGED   = 2'd1
`ifdef RV_IOPMP_ERR_MSI_EN
    ,ST_MSI_PEND = 2'd2
`endif
  } state_e;

  state_e                   state_q;
  logic                     err_v_q;
  logic [1:0]               ttype_q;
  logic [2:0]               etype_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [SID_WIDTH-1:0]     sid_q;
  logic [EIDX_WIDTH-1:0]    eid_q;
  logic                     ovf_q;
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q;
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt_d;

  logic err_hit_w;
  logic capture_w;
  logic clear_w;
  logic drop_w;
  logic msi_go_w;

`ifdef RV_IOPMP_ERR_MSI_EN
  logic                  msi_req_q;
  logic                  clr_pend_q;
  logic [ADDR_WIDTH-1:0] msi_addr_q;
  logic [10:0]           msi_data_q;
`endif

  // A clear arriving with a new error is a clear followed by a fresh capture.
  always_comb begin
    err_hit_w = dl.err_valid & dl.err_transaction;
    capture_w = 1'b0;
    clear_w   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        capture_w = err_hit_w;
      end
      ST_LOGGED: begin
        clear_w   = err_clr_i;
        capture_w = err_clr_i & err_hit_w;
      end
`ifdef RV_IOPMP_ERR_MSI_EN
      // Clears wait here until the MSI handshake completes.
      ST_MSI_PEND: begin
        clear_w   = msi_ready_i & (clr_pend_q | err_clr_i);
        capture_w = clear_w & err_hit_w;
      end
`endif
      default: begin
        capture_w = 1'b0;
      end
    endcase
    drop_w    = err_hit_w & ~capture_w;
    ovf_cnt_d = (ovf_cnt_q == {OVF_CNT_WIDTH{1'b1}}) ? ovf_cnt_q
                                                     : ovf_cnt_q + OVF_CNT_WIDTH'(1);
`ifdef RV_IOPMP_ERR_MSI_EN
    msi_go_w  = ie_i & msi_en_i;
`else
    msi_go_w  = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      err_v_q    <= 1'b0;
      ttype_q    <= '0;
      etype_q    <= '0;
      addr_q     <= '0;
      sid_q      <= '0;
      eid_q      <= '0;
      ovf_q      <= 1'b0;
      ovf_cnt_q  <= '0;
`ifdef RV_IOPMP_ERR_MSI_EN
      msi_req_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      msi_addr_q <= '0;
      msi_data_q <= '0;
`endif
    end else if (capture_w) begin
      err_v_q    <= 1'b1;
      ttype_q    <= dl.access_type;
      etype_q    <= dl.err_type;
      addr_q     <= dl.addr;
      sid_q      <= dl.sid;
      eid_q      <= dl.err_entry_index;
      ovf_q      <= 1'b0;
      ovf_cnt_q  <= '0;
`ifdef RV_IOPMP_ERR_MSI_EN
      state_q    <= msi_go_w ? ST_MSI_PEND : ST_LOGGED;
      msi_req_q  <= msi_go_w;
      clr_pend_q <= 1'b0;
      msi_addr_q <= msi_addr_i;
      msi_data_q <= msi_data_i;
`else
      state_q    <= msi_go_w ? ST_IDLE : ST_LOGGED;
`endif
    end else if (clear_w) begin
      state_q    <= ST_IDLE;
      err_v_q    <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_cnt_q  <= '0;
`ifdef RV_IOPMP_ERR_MSI_EN
      msi_req_q  <= 1'b0;
      clr_pend_q <= 1'b0;
`endif
    end else begin
      if (drop_w) begin
        ovf_q     <= 1'b1;
        ovf_cnt_q <= ovf_cnt_d;
      end
`ifdef RV_IOPMP_ERR_MSI_EN
      if (state_q == ST_MSI_PEND) begin
        if (err_clr_i) begin
          clr_pend_q <= 1'b1;
        end
        if (msi_ready_i) begin
          state_q   <= ST_LOGGED;
          msi_req_q <= 1'b0;
        end
      end
`endif
    end
  end

  assign err_v_o     = err_v_q;
  assign err_ttype_o = ttype_q;
  assign err_etype_o = etype_q;
  assign err_addr_o  = addr_q;
  assign err_sid_o   = sid_q;
  assign err_eid_o   = eid_q;
  assign err_ovf_o   = ovf_q;
  assign ovf_cnt_o   = ovf_cnt_q;

`ifdef RV_IOPMP_ERR_MSI_EN
  assign irq_o      = err_v_q & ie_i & ~msi_en_i;
  assign msi_req_o  = msi_req_q;
  assign msi_addr_o = msi_addr_q;
  assign msi_data_o = msi_data_q;
`else
  assign irq_o      = err_v_q & ie_i;
`endif

endmodule

`default_nettype wire
